cache_controller: RTL
=====================

Name: cache_controller

Overview:
- Sequences the 2-way, 64-set, 2-word-line cache (19-bit byte address: tag [18:9], index [8:3], word select [2]) between the ARM memory stage and the SRAM controller.
- Read hits are served from the cache in the same cycle.
- Read misses fetch a 64-bit line from SRAM and fill the cache.
- Writes are write-through, no-allocate; on a write hit the cached line is refreshed.
- Drives the cache's en_read/en_write/update_data controls and the pipeline ready (freeze = ~ready).

Parameters:
- BASE_ADDR, 1024, byte address of data memory base; subtracted before cache/SRAM addressing.
- SRAM_ADDR_W, 32, width of the SRAM-side address.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_r_en  in  1  memory-stage load request
- mem_w_en  in  1  memory-stage store request
- address  in  32  byte address from memory stage
- wdata  in  32  store data
- rdata  out  32  load data
- ready  out  1  request complete / no stall
- cache_address  out  19  address to cache
- cache_en_read  out  1  cache read strobe (LRU update)
- cache_en_write  out  1  cache write strobe
- cache_update_data  out  1  1 = refresh existing line, 0 = fill by LRU
- cache_in_data1  out  32  line word 0
- cache_in_data2  out  32  line word 1
- cache_hit  in  1  cache hit (combinational)
- cache_out_data  in  32  cache word at cache_address
- sram_address  out  SRAM_ADDR_W  SRAM byte address (offset-removed)
- sram_wdata  out  32  SRAM store data
- sram_r_en  out  1  SRAM line read request
- sram_w_en  out  1  SRAM word write request
- sram_rdata  in  64  SRAM line, [31:0] = word 0, [63:32] = word 1
- sram_ready  in  1  SRAM op complete (single-cycle pulse)

Behaviour:
- Offset address a = address - BASE_ADDR (32-bit wrap).
- cache_address = a[18:0], except in W_PEEK, where bit 2 is inverted.
- sram_address = a, except for line reads, which use a with bits [2:0] cleared.
- Requests are held stable by the pipeline until ready=1.
- If mem_w_en and mem_r_en are both high, the write takes priority.
- FSM states: IDLE, R_MISS, W_PEEK, W_SRAM.
- IDLE:
  - No request: ready=1, all strobes 0.
  - mem_r_en with cache_hit: cache_en_read=1, rdata=cache_out_data, ready=1; stay in IDLE. Read-hit latency is 0 cycles.
  - mem_r_en without cache_hit: ready=0; go to R_MISS.
  - mem_w_en: ready=0; go to W_PEEK.
- R_MISS:
  - sram_r_en=1 and ready=0 until sram_ready.
  - On sram_ready: cache_en_write=1, update_data=0, in_data1=sram_rdata[31:0], in_data2=sram_rdata[63:32]; rdata=a[2] ? sram_rdata[63:32] : sram_rdata[31:0]; ready=1; go to IDLE.
- W_PEEK (one cycle):
  - Present the sibling word address.
  - Latch sib_hit=cache_hit and sib_data=cache_out_data into registers.
  - Go to W_SRAM.
- W_SRAM:
  - sram_w_en=1, sram_wdata=wdata, ready=0 until sram_ready.
  - On sram_ready with sib_hit=1: cache_en_write=1, update_data=1; the line is {wdata, sib_data} ordered by a[2].
  - On sram_ready: ready=1; go to IDLE.
- cache_en_read is 0 outside the IDLE read case.
- Reset:
  - Synchronous; state=IDLE, sib_hit=0, sib_data=0, all strobes 0.
  - Reset mid-operation abandons the transaction; SRAM strobes drop after the reset edge.
  - ready follows IDLE rules after reset.
- No outstanding-request queue: at most one transaction is in flight.
- sram_ready outside R_MISS/W_SRAM is ignored.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - Each counts completed reads: hit at the IDLE hit cycle, miss at R_MISS completion.
  - Both clear on rst and saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package arm_cache_pkg holds:
  - State enum (IDLE, R_MISS, W_PEEK, W_SRAM).
  - Cache address width (19).
  - TAG/INDEX/WORD bit positions.
  - Line width (64).
- Optional sub-module cache_stats_counter: saturating counter, instantiated twice under CACHE_STATS_EN. The FSM stays in the top module.

Test Plan:
- Read miss then hit: read address 1024+0x10; sram_ready after 4 cycles with rdata 0xBBBB_BBBB_AAAA_AAAA.
  - Expect sram_address 0x10, then a fill with in_data1=0xAAAAAAAA and rdata=0xAAAAAAAA.
  - Re-read 1024+0x14: expect same-cycle ready and rdata 0xBBBBBBBB.
- Write hit: after the fill above, write 0x12345678 to 1024+0x10.
  - Expect W_PEEK cache_address 0x14 and sram_w_en.
  - On sram_ready: update_data=1, in_data1=0x12345678, in_data2=0xBBBBBBBB.
- Write miss: write to 1024+0x800 (no line).
  - Expect an SRAM write only; cache_en_write=0; ready on sram_ready.
- Simultaneous request: mem_r_en=mem_w_en=1.
  - Expect the write path; no sram_r_en.
- Reset mid-miss: assert rst in R_MISS before sram_ready.
  - Next cycle: sram_r_en=0, state IDLE.
  - A later sram_ready pulse causes no cache write.
- CACHE_STATS_EN: 3 hits and 2 misses → hit_count=3, miss_count=2; both 0 after rst.

Source files
------------

// File: rtl/cache_controller_pkg.sv
// -----------------------------------------------------------------------------
// arm_cache_pkg
// Shared types and constants for the ARM memory-stage cache controller:
//   - controller FSM state enum
//   - cache address width and tag/index/word-select bit positions
//   - cache line width and a helper that selects one word of a line
// -----------------------------------------------------------------------------
package arm_cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      R_MISS,
      W_PEEK,
      W_SRAM
   } cc_state_e;

   localparam int unsigned CACHE_ADDR_W = 19;
   localparam int unsigned TAG_MSB      = 18;
   localparam int unsigned TAG_LSB      = 9;
   localparam int unsigned INDEX_MSB    = 8;
   localparam int unsigned INDEX_LSB    = 3;
   localparam int unsigned WORD_BIT     = 2;
   localparam int unsigned LINE_W       = 64;

   // Word 0 lives in [31:0], word 1 in [63:32].
   function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                             input logic              sel);
      return sel ? line[63:32] : line[31:0];
   endfunction

endpackage

// File: rtl/cache_controller_if.sv
// -----------------------------------------------------------------------------
// cache_controller_if
// SRAM-controller bus between the cache controller (master) and the SRAM
// controller (slave).
//   sram_address  master->slave  byte address (offset-removed)
//   sram_wdata    master->slave  store data
//   sram_r_en     master->slave  64-bit line read request
//   sram_w_en     master->slave  32-bit word write request
//   sram_rdata    slave->master  line, [31:0] = word 0, [63:32] = word 1
//   sram_ready    slave->master  single-cycle completion pulse
// -----------------------------------------------------------------------------
interface cache_controller_if #(
   parameter int unsigned SRAM_ADDR_W = 32
);
   import arm_cache_pkg::*;

   logic [SRAM_ADDR_W-1:0] sram_address;
   logic [31:0]            sram_wdata;
   logic                   sram_r_en;
   logic                   sram_w_en;
   logic [LINE_W-1:0]      sram_rdata;
   logic                   sram_ready;

   modport master (
      output sram_address, sram_wdata, sram_r_en, sram_w_en,
      input  sram_rdata, sram_ready
   );

   modport slave (
      input  sram_address, sram_wdata, sram_r_en, sram_w_en,
      output sram_rdata, sram_ready
   );

endinterface

// File: rtl/cache_controller_stats.sv
// -----------------------------------------------------------------------------
// cache_stats_counter
// Saturating event counter used for the optional read hit/miss statistics.
//   clk      system clock
//   rst      synchronous active-high clear
//   inc_i    count one event this cycle
//   count_o  current count, sticks at all-ones
// -----------------------------------------------------------------------------
module cache_stats_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
// Sequences a 2-way, 64-set, 2-word-line cache between the ARM memory stage
// and the SRAM controller. Read hits complete in the request cycle, read
// misses fill a full line from SRAM, writes are write-through/no-allocate
// with an in-place refresh of the line on a write hit.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_r_en, mem_w_en       memory-stage load/store request (held until ready)
//   address, wdata           request byte address and store data
//   rdata, ready             load data, request complete (freeze = ~ready)
//   cache_address            address presented to the cache
//   cache_en_read            cache read strobe (LRU update)
//   cache_en_write           cache write strobe
//   cache_update_data        1 = refresh existing line, 0 = fill by LRU
//   cache_in_data1/2         line words 0/1 for a cache write
//   cache_hit, cache_out_data  combinational cache lookup result
//   sram                     SRAM bus (cache_controller_if.master)
//   hit_count, miss_count    completed-read statistics (CACHE_STATS_EN only)
//
// Build option: define CACHE_STATS_EN to add the saturating hit/miss counters.
// -----------------------------------------------------------------------------
module cache_controller
   import arm_cache_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int unsigned SRAM_ADDR_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_r_en,
   input  logic                    mem_w_en,
   input  logic [31:0]             address,
   input  logic [31:0]             wdata,
   output logic [31:0]             rdata,
   output logic                    ready,
   output logic [CACHE_ADDR_W-1:0] cache_address,
   output logic                    cache_en_read,
   output logic                    cache_en_write,
   output logic                    cache_update_data,
   output logic [31:0]             cache_in_data1,
   output logic [31:0]             cache_in_data2,
   input  logic                    cache_hit,
   input  logic [31:0]             cache_out_data,
   cache_controller_if.master      sram
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count
`endif
);

   cc_state_e state_q, state_d;
   logic        sib_hit_q, sib_hit_d;
   logic [31:0] sib_data_q, sib_data_d;

   logic [31:0] a;
   logic [31:0] line_a;
   logic        word_sel;

   logic [SRAM_ADDR_W-1:0] sram_addr_d;
   logic                   sram_r_en_d;
   logic                   sram_w_en_d;

   assign a        = address - BASE_ADDR;
   assign line_a   = {a[31:3], 3'b000};
   assign word_sel = a[WORD_BIT];

   // W_PEEK looks up the other word of the same line so a write hit can
   // rebuild the full line without a second SRAM access.
   assign cache_address = {a[TAG_MSB:TAG_LSB], a[INDEX_MSB:INDEX_LSB],
                           word_sel ^ (state_q == W_PEEK), a[1:0]};

   always_comb begin
      state_d           = state_q;
      sib_hit_d         = sib_hit_q;
      sib_data_d        = sib_data_q;
      ready             = 1'b1;
      rdata             = '0;
      cache_en_read     = 1'b0;
      cache_en_write    = 1'b0;
      cache_update_data = 1'b0;
      cache_in_data1    = '0;
      cache_in_data2    = '0;
      sram_r_en_d       = 1'b0;
      sram_w_en_d       = 1'b0;
      sram_addr_d       = SRAM_ADDR_W'(a);

      unique case (state_q)
         IDLE: begin
            if (mem_w_en) begin
               ready   = 1'b0;
               state_d = W_PEEK;
            end else if (mem_r_en) begin
               if (cache_hit) begin
                  cache_en_read = 1'b1;
                  rdata         = cache_out_data;
               end else begin
                  ready   = 1'b0;
                  state_d = R_MISS;
               end
            end
         end

         R_MISS: begin
            sram_r_en_d = 1'b1;
            sram_addr_d = SRAM_ADDR_W'(line_a);
            ready       = 1'b0;
            if (sram.sram_ready) begin
               cache_en_write = 1'b1;
               cache_in_data1 = sram.sram_rdata[31:0];
               cache_in_data2 = sram.sram_rdata[63:32];
               rdata          = line_word(sram.sram_rdata, word_sel);
               ready          = 1'b1;
               state_d        = IDLE;
            end
         end

         W_PEEK: begin
            ready      = 1'b0;
            sib_hit_d  = cache_hit;
            sib_data_d = cache_out_data;
            state_d    = W_SRAM;
         end

         W_SRAM: begin
            sram_w_en_d = 1'b1;
            ready       = 1'b0;
            if (sram.sram_ready) begin
               if (sib_hit_q) begin
                  cache_en_write    = 1'b1;
                  cache_update_data = 1'b1;
                  cache_in_data1    = word_sel ? sib_data_q : wdata;
                  cache_in_data2    = word_sel ? wdata : sib_data_q;
               end
               ready   = 1'b1;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sib_hit_q  <= 1'b0;
         sib_data_q <= '0;
      end else begin
         state_q    <= state_d;
         sib_hit_q  <= sib_hit_d;
         sib_data_q <= sib_data_d;
      end
   end

   assign sram.sram_address = sram_addr_d;
   assign sram.sram_wdata   = wdata;
   assign sram.sram_r_en    = sram_r_en_d;
   assign sram.sram_w_en    = sram_w_en_d;

`ifdef CACHE_STATS_EN
   logic hit_evt, miss_evt;

   assign hit_evt  = (state_q == IDLE) && !mem_w_en && mem_r_en && cache_hit;
   assign miss_evt = (state_q == R_MISS) && sram.sram_ready;

   cache_stats_counter #(.WIDTH(32)) u_hit_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (hit_evt),
      .count_o (hit_count)
   );

   cache_stats_counter #(.WIDTH(32)) u_miss_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (miss_evt),
      .count_o (miss_count)
   );
`endif

endmodule
